// File: rtl/bus_decoder_if.sv
// -----------------------------------------------------------------------------
// bus_decoder_if
//
// Purpose:
//   Bundles every handshake and data signal around bus_decoder into a single
//   interface. It carries the host side (request in, completion out) and the
//   device side (strobes out, acks and read data in).
//
// Parameters:
//   D       - data width
//   a_bits  - address width
//   devices - number of slave devices
//
// Signals (host side):
//   req, we, a, wdata          : access request from the host
//   busy, done, error          : access status back to the host
//   read_data                  : read result, valid with done
// Signals (device side):
//   dev_a, dev_wdata           : latched address / write data for the devices
//   read_strobes/write_strobes : one-cycle per-device access pulses
//   acks                       : per-device completion
//   read_datas                 : packed device read data, device 0 at LSBs
//
// Modports:
//   slave  - the decoder's view (drives status and strobes)
//   master - the environment's view (drives the request and device replies)
// -----------------------------------------------------------------------------
interface bus_decoder_if #(
  parameter int D       = 8,
  parameter int a_bits  = 16,
  parameter int devices = 4
);

  // Host request
  logic                   req;
  logic                   we;
  logic [a_bits-1:0]      a;
  logic [D-1:0]           wdata;

  // Host status
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [D-1:0]           read_data;

  // Device side
  logic [a_bits-1:0]      dev_a;
  logic [D-1:0]           dev_wdata;
  logic [devices-1:0]     read_strobes;
  logic [devices-1:0]     write_strobes;
  logic [devices-1:0]     acks;
  logic [D*devices-1:0]   read_datas;

  modport slave (
    input  req,
    input  we,
    input  a,
    input  wdata,
    input  acks,
    input  read_datas,
    output busy,
    output done,
    output error,
    output read_data,
    output dev_a,
    output dev_wdata,
    output read_strobes,
    output write_strobes
  );

  modport master (
    output req,
    output we,
    output a,
    output wdata,
    output acks,
    output read_datas,
    input  busy,
    input  done,
    input  error,
    input  read_data,
    input  dev_a,
    input  dev_wdata,
    input  read_strobes,
    input  write_strobes
  );

endinterface

// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
//
// Purpose:
//   Single-master address decoder. An accepted request is matched against a
//   table of device apertures; the lowest-indexed matching device gets a
//   one-cycle read or write strobe, and the decoder then waits for that
//   device's ack (bounded by TIMEOUT cycles). Completion is reported with a
//   one-cycle done pulse carrying error and read_data.
//
// Parameters:
//   D               - data width
//   B               - width of each base address field
//   A               - width of each aperture-width field
//   a_bits          - decoded address width
//   devices         - slave count
//   base_addresses  - devices*B packed base addresses, device 0 at LSBs
//   aperture_widths - devices*A packed aperture widths (bits below the
//                     compared field); 0 means exact address match
//   TIMEOUT         - maximum number of wait cycles after the strobe
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; aborts any access without done
//   bus   - bus_decoder_if.slave (request/status and device handshake)
// -----------------------------------------------------------------------------
module bus_decoder #(
  parameter int                   D               = 8,
  parameter int                   B               = 16,
  parameter int                   A               = 4,
  parameter int                   a_bits          = B,
  parameter int                   devices         = 4,
  parameter logic [devices*B-1:0] base_addresses  = '0,
  parameter logic [devices*A-1:0] aperture_widths = '0,
  parameter int                   TIMEOUT         = 15
) (
  input  logic          clk,
  input  logic          reset,
  bus_decoder_if.slave  bus
);

  // Index and counter widths; counter must be able to hold TIMEOUT itself.
  localparam int IW = (devices > 1) ? $clog2(devices) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [CW-1:0]      cnt_q,       cnt_d;
  logic [IW-1:0]      sel_q,       sel_d;
  logic               match_q,     match_d;
  logic               we_q,        we_d;
  logic [a_bits-1:0]  dev_a_q,     dev_a_d;
  logic [D-1:0]       dev_wdata_q, dev_wdata_d;
  logic [D-1:0]       rdata_q,     rdata_d;
  logic               err_q,       err_d;

  // ---------------------------------------------------------------------------
  // Address decode: one comparator per device against the live request
  // address. Bits below the aperture width are masked out of the compare.
  // ---------------------------------------------------------------------------
  logic [devices-1:0] match;

  for (genvar gi = 0; gi < devices; gi++) begin : g_decode
    localparam int                W_GI    = int'(aperture_widths[gi*A +: A]);
    localparam logic [a_bits-1:0] BASE_GI = a_bits'(base_addresses[gi*B +: B]);
    // An aperture as wide as the address matches everything.
    localparam logic [a_bits-1:0] MASK_GI =
      (W_GI >= a_bits) ? '0 : ({a_bits{1'b1}} << W_GI);

    assign match[gi] = ((bus.a & MASK_GI) == (BASE_GI & MASK_GI));
  end

  // Lowest matching index wins: scan downwards so the last hit is the lowest.
  logic [IW-1:0] sel_new;
  logic          any_match;

  always_comb begin
    sel_new   = '0;
    any_match = 1'b0;
    for (int i = devices - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_new   = IW'(i);
        any_match = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selected-device views: ack and read-data slice of the latched device.
  // ---------------------------------------------------------------------------
  logic [D-1:0]       rd_slice [devices];
  logic [devices-1:0] sel_onehot;

  for (genvar gi = 0; gi < devices; gi++) begin : g_slices
    assign rd_slice[gi]   = bus.read_datas[gi*D +: D];
    assign sel_onehot[gi] = (sel_q == IW'(gi));
  end

  logic         ack_sel;
  logic [D-1:0] rd_sel;

  assign ack_sel = |(bus.acks & sel_onehot);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < devices; i++) begin
      if (sel_onehot[i]) begin
        rd_sel = rd_slice[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    match_d     = match_q;
    we_d        = we_q;
    dev_a_d     = dev_a_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          sel_d       = sel_new;
          match_d     = any_match;
          we_d        = bus.we;
          dev_a_d     = bus.a;
          dev_wdata_d = bus.wdata;
          if (any_match) begin
            state_d = STROBE;
          end else begin
            // Nothing decodes: report the error immediately, no strobe.
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '1;
          end
        end
      end

      STROBE: begin
        if (ack_sel) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? '1 : rd_sel;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end

      WAIT: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (ack_sel) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? '1 : rd_sel;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          cnt_d   = cnt_q + CW'(1);
          err_d   = 1'b1;
          rdata_d = '1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      match_q     <= 1'b0;
      we_q        <= 1'b0;
      dev_a_q     <= '0;
      dev_wdata_q <= '0;
      rdata_q     <= '1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      match_q     <= match_d;
      we_q        <= we_d;
      dev_a_q     <= dev_a_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state, so strobes last exactly the
  // single STROBE cycle)
  // ---------------------------------------------------------------------------
  logic strobe_active;

  assign strobe_active     = (state_q == STROBE) && match_q;

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.error         = (state_q == DONE) && err_q;
  assign bus.read_data     = rdata_q;
  assign bus.dev_a         = dev_a_q;
  assign bus.dev_wdata     = dev_wdata_q;
  assign bus.read_strobes  = (strobe_active && !we_q) ? sel_onehot : '0;
  assign bus.write_strobes = (strobe_active &&  we_q) ? sel_onehot : '0;

endmodule
